// File: rtl/bram_block_mover.sv
// Copies len bytes from src to dst inside a single-port bram, alternating read and write cycles.
// Define BLOCK_MOVER_CHECKSUM_EN to build the running checksum of the copied bytes.
module bram_block_mover #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_readWrite,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [ADDR_W:0]   remaining;

  // Outputs are registered on the transition into the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      src_ptr       <= '0;
      dst_ptr       <= '0;
      remaining     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_addr      <= '0;
      mem_readWrite <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          mem_addr      <= '0;
          mem_readWrite <= 1'b0;
          busy          <= 1'b0;
          if (start) begin
            if (len != '0) begin
              src_ptr   <= src;
              dst_ptr   <= dst;
              remaining <= len;
              mem_addr  <= src;
              busy      <= 1'b1;
              state     <= READ;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        READ: begin
          mem_addr      <= dst_ptr;
          mem_readWrite <= 1'b1;
          state         <= WRITE;
        end
        WRITE: begin
          src_ptr       <= src_ptr + 1'b1;
          dst_ptr       <= dst_ptr + 1'b1;
          remaining     <= remaining - LEN_ONE;
          mem_readWrite <= 1'b0;
          if (remaining != LEN_ONE) begin
            mem_addr <= src_ptr + 1'b1;
            state    <= READ;
          end else begin
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read data from the previous edge is forwarded straight to the write port.
  assign mem_data = (state == WRITE) ? mem_rdata : '0;

`ifdef BLOCK_MOVER_CHECKSUM_EN
  function automatic logic [DATA_W-1:0] add_wrap(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum <= '0;
    end else if (state == IDLE && start) begin
      checksum <= '0;
    end else if (state == WRITE) begin
      checksum <= add_wrap(checksum, mem_rdata);
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_bram_block_mover.sv
// Scoreboard bench for bram_block_mover with a behavioural 8x256 bram (registered read data).
module tb_bram_block_mover;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] src = '0;
  logic [7:0] dst = '0;
  logic [8:0] len = '0;
  logic       busy;
  logic       done;
  logic [7:0] checksum;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_readWrite;
  logic [7:0] mem_rdata;

  logic [7:0] bram [256];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int busy_run = 0;

  typedef struct { int addr; int data; int cyc; } wr_t;
  typedef struct { int cyc; int ck; int blen; } dn_t;
  wr_t wq[$];
  dn_t dq[$];

  bram_block_mover #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .checksum(checksum), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_readWrite(mem_readWrite), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_readWrite) bram[mem_addr] <= mem_data;
    else mem_rdata <= bram[mem_addr];
  end

  function automatic int exp_ck(input int v);
`ifdef BLOCK_MOVER_CHECKSUM_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT writes or signals done.
  always @(negedge clk) begin
    if (reset) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (mem_readWrite) begin
        if (wq.size() == 0) begin
          chk("unexpected_write_addr", int'(mem_addr), -1);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("write_addr", int'(mem_addr), e.addr);
          chk("write_data", int'(mem_data), e.data);
          chk("write_cycle", cyc, e.cyc);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", cyc, -1);
        end else begin
          dn_t d;
          d = dq.pop_front();
          chk("done_cycle", cyc, d.cyc);
          chk("done_checksum", int'(checksum), d.ck);
          chk("busy_cycles", busy_run, d.blen);
          chk("busy_at_done", int'(busy), 0);
        end
        busy_run = 0;
      end
    end
  end

  task automatic push_w(input int a, input int d, input int c);
    wr_t e;
    e.addr = a; e.data = d; e.cyc = c;
    wq.push_back(e);
  endtask

  task automatic push_d(input int c, input int ck, input int blen);
    dn_t d;
    d.cyc = c; d.ck = exp_ck(ck); d.blen = blen;
    dq.push_back(d);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && (wq.size() != 0 || dq.size() != 0); i++) @(negedge clk);
    chk(name, wq.size() + dq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic fire(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l);
    src = s; dst = d; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    for (int i = 0; i < 256; i++) bram[i] = 8'(255 - i);
    mem_rdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_checksum", int'(checksum), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_rw", int'(mem_readWrite), 0);
    chk("rst_mem_data", int'(mem_data), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // len=4 from 00 to 10
    c0 = cyc + 1;
    push_w(8'h10, 8'hFF, c0 + 1); push_w(8'h11, 8'hFE, c0 + 3);
    push_w(8'h12, 8'hFD, c0 + 5); push_w(8'h13, 8'hFC, c0 + 7);
    push_d(c0 + 8, 8'hF6, 8);
    fire(8'h00, 8'h10, 9'd4);
    drain("drain_len4");

    // len=0: immediate done, checksum cleared
    c0 = cyc + 1;
    push_d(c0, 0, 0);
    fire(8'h44, 8'h55, 9'd0);
    drain("drain_len0");

    // len=1
    c0 = cyc + 1;
    push_w(8'h80, 8'hFA, c0 + 1);
    push_d(c0 + 2, 8'hFA, 2);
    fire(8'h05, 8'h80, 9'd1);
    drain("drain_len1");

    // source pointer wraps FF->00
    c0 = cyc + 1;
    push_w(8'h20, 8'h01, c0 + 1); push_w(8'h21, 8'h00, c0 + 3);
    push_w(8'h22, 8'hFF, c0 + 5);
    push_d(c0 + 6, 8'h00, 6);
    fire(8'hFE, 8'h20, 9'd3);
    drain("drain_wrap");

    // second start while busy must be ignored
    c0 = cyc + 1;
    push_w(8'h40, 8'hCF, c0 + 1); push_w(8'h41, 8'hCE, c0 + 3);
    push_w(8'h42, 8'hCD, c0 + 5); push_w(8'h43, 8'hCC, c0 + 7);
    push_d(c0 + 8, 8'h36, 8);
    fire(8'h30, 8'h40, 9'd4);
    repeat (2) @(negedge clk);
    fire(8'h50, 8'h60, 9'd2);
    drain("drain_ignored_start");

    // abort with reset after the second write edge
    c0 = cyc + 1;
    push_w(8'h90, 8'h8F, c0 + 1); push_w(8'h91, 8'h8E, c0 + 3);
    fire(8'h70, 8'h90, 9'd4);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_mem_rw", int'(mem_readWrite), 0);
    chk("abort_pending", wq.size() + dq.size(), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    c0 = cyc + 1;
    push_w(8'h90, 8'h8F, c0 + 1); push_w(8'h91, 8'h8E, c0 + 3);
    push_w(8'h92, 8'h8D, c0 + 5); push_w(8'h93, 8'h8C, c0 + 7);
    push_d(c0 + 8, 8'h36, 8);
    fire(8'h70, 8'h90, 9'd4);
    drain("drain_after_abort");

    chk("mem_10", int'(bram[8'h10]), 8'hFF);
    chk("mem_13", int'(bram[8'h13]), 8'hFC);
    chk("mem_80", int'(bram[8'h80]), 8'hFA);
    chk("mem_20", int'(bram[8'h20]), 8'h01);
    chk("mem_22", int'(bram[8'h22]), 8'hFF);
    chk("mem_43", int'(bram[8'h43]), 8'hCC);
    chk("mem_60_untouched", int'(bram[8'h60]), 8'h9F);
    chk("mem_93", int'(bram[8'h93]), 8'h8C);
    chk("mem_55_untouched", int'(bram[8'h55]), 8'hAA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_block_mover.md
Name: bram_block_mover

Overview:
- Initiator for the single-port 8x256 bram command interface (addr, data, readWrite, registered out).
- On a start pulse, copies a block of len bytes from a source address to a destination address inside the bram.
- Uses alternating read and write cycles through the single port.
- Sits between control logic and the bram, owning the bram port whenever it is busy.

Parameters:
- ADDR_W, 8, bram address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, bram data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request pulse; sampled only in IDLE.
- src  input  ADDR_W  first source address; captured with start.
- dst  input  ADDR_W  first destination address; captured with start.
- len  input  ADDR_W+1  byte count, 0..256; captured with start.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle completion pulse.
- checksum  output  DATA_W  running sum of copied bytes (see Optional Feature).
- mem_addr  output  ADDR_W  to bram addr.
- mem_data  output  DATA_W  to bram data.
- mem_readWrite  output  1  to bram readWrite; 0 = read, 1 = write.
- mem_rdata  input  DATA_W  from bram out; valid the cycle after a read edge.

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, done=0, checksum=0, mem_addr=0, mem_data=0, mem_readWrite=0; internal pointers and counter cleared.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - mem_readWrite=0, mem_addr=0.
  - start=1 with len!=0: capture src/dst/len, go to READ, busy=1.
  - start=1 with len=0: go to DONE; no bram access.
- READ:
  - mem_addr=src_ptr, mem_readWrite=0.
  - Next state WRITE. The bram registers bram[src_ptr] onto mem_rdata at this edge.
- WRITE:
  - mem_addr=dst_ptr, mem_readWrite=1, mem_data=mem_rdata (combinational pass-through; stable within the cycle).
  - At the edge: src_ptr+1, dst_ptr+1 (both wrap FF->00), remaining-1.
  - Next state READ if remaining!=1, else DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle; mem_readWrite=0.
  - Next state IDLE.
- Latency: start sampled at edge E0. Byte k is written at edge E0+2k+2. done is high in the cycle after edge E0+2*len (len=0: cycle after E0). The block accepts the next start one cycle after done.
- busy is high from the cycle after the start edge through the last WRITE cycle.
- Copy is forward and ascending. For overlapping ranges with dst>src, bytes already overwritten are re-read; this is the defined behaviour, no overlap detection.
- len=256 copies the whole array once; the counter is ADDR_W+1 bits.
- start while not IDLE: ignored, no queueing.
- reset mid-transfer: abort immediately and return to IDLE; partial writes already committed remain unless the bram is also reset.
- mem_* outputs are driven purely from state and pointers; no glitching write-enable outside WRITE.

Optional Feature:
- Macro: BLOCK_MOVER_CHECKSUM_EN.
- Defined: checksum cleared to 0 when a start is accepted; on each WRITE edge, checksum <= checksum + mem_rdata (mod 2^DATA_W). Holds its value after done until the next accepted start or reset.
- Undefined: checksum is constant 0 and no adder is synthesised.

Test Plan:
- Bram at reset contents (bram[i]=255-i): start src=00 dst=10 len=4 -> bram[10..13]=FF,FE,FD,FC; done at E0+8; with macro, checksum=F6.
- len=1, src=05 dst=80 -> mem_readWrite high only in the cycle after E0+1; bram[80]=FA; done in the cycle after E0+2; busy high for exactly 2 cycles.
- Wrap: src=FE dst=20 len=3 -> bram[20..22]=01,00,FF; src_ptr wraps FF->00.
- len=0 -> done the cycle after E0; mem_readWrite never 1; bram unchanged; with macro, checksum=0.
- start pulsed again during a len=4 transfer with different src/dst -> ignored; only the original transfer is performed and a single done is produced.
- Assert reset after the second write edge of a len=4 transfer -> busy=0 and mem_readWrite=0 immediately; a new start after reset release performs a full, correct transfer.
